// File: rtl/alu_seq_if.sv
// Start/busy/done handshake bundle between the control unit (master) and alu_seq (slave).
interface alu_seq_if #(
   parameter int DW = 8
);
   logic          start;
   logic [3:0]    op;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          busy;
   logic          done;
   logic [DW-1:0] result;
   logic          zf;
   logic          cf;

   modport master (output start, op, a, b, input busy, done, result, zf, cf);
   modport slave  (input start, op, a, b, output busy, done, result, zf, cf);
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops latency 1; shifts k+1, MUL/DIV DW+1; start ignored while busy.
// Optional divider (op 13) enabled by defining ALU_SEQ_DIV_EN.
module alu_seq #(
   parameter int DW  = 8,
   parameter int SHW = 3
) (
   input  logic       clk,
   input  logic       rst,
   alu_seq_if.slave   bus
);
   localparam int CNT_W = SHW + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_INC = 4'd6;
   localparam logic [3:0] OP_DEC = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_SAR = 4'd10;
   localparam logic [3:0] OP_MUL = 4'd11;
`ifdef ALU_SEQ_DIV_EN
   localparam logic [3:0] OP_DIV = 4'd13;
`endif

   typedef enum logic {IDLE, EXEC} state_t;

   state_t        state;
   logic [3:0]    op_q;
   logic [DW-1:0] wrk;     // shift value / MUL low product half / DIV quotient
   logic [DW-1:0] acc;     // MUL high product half / DIV remainder
   logic [DW-1:0] opd;     // MUL multiplicand / DIV divisor
   logic [CNT_W-1:0] cnt;
   logic          busy_q;
   logic          done_q;
   logic [DW-1:0] result_q;
   logic          zf_q;
   logic          cf_q;

   logic [DW-1:0] sc_res;
   logic          sc_cf;
   logic [DW:0]   ext;
   logic          is_shift;
   logic          is_multi;
   logic [SHW-1:0] k;

   logic [DW-1:0] step_wrk;
   logic [DW-1:0] step_acc;
   logic          step_cf;
   logic [DW:0]   mul_sum;
`ifdef ALU_SEQ_DIV_EN
   logic [DW:0]   r_sh;
   logic [DW:0]   diff;
`endif

   assign k        = bus.b[SHW-1:0];
   assign is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_SAR);

   always_comb begin
      is_multi = (is_shift && (k != '0)) || (bus.op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
      if ((bus.op == OP_DIV) && (bus.b != '0))
         is_multi = 1'b1;
`endif
   end

   // Single-cycle datapath; also covers zero-length shifts and divide-by-zero.
   always_comb begin
      sc_res = bus.a;
      sc_cf  = 1'b0;
      ext    = '0;
      case (bus.op)
         OP_ADD: begin
            ext    = {1'b0, bus.a} + {1'b0, bus.b};
            sc_res = ext[DW-1:0];
            sc_cf  = ext[DW];
         end
         OP_SUB: begin
            ext    = {1'b0, bus.a} - {1'b0, bus.b};
            sc_res = ext[DW-1:0];
            sc_cf  = ext[DW];
         end
         OP_AND: sc_res = bus.a & bus.b;
         OP_OR:  sc_res = bus.a | bus.b;
         OP_XOR: sc_res = bus.a ^ bus.b;
         OP_NOT: sc_res = ~bus.a;
         OP_INC: begin
            ext    = {1'b0, bus.a} + (DW+1)'(1);
            sc_res = ext[DW-1:0];
            sc_cf  = ext[DW];
         end
         OP_DEC: begin
            ext    = {1'b0, bus.a} - (DW+1)'(1);
            sc_res = ext[DW-1:0];
            sc_cf  = ext[DW];
         end
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            sc_res = '1;
            sc_cf  = 1'b1;
         end
`endif
         default: begin
            sc_res = bus.a;
            sc_cf  = 1'b0;
         end
      endcase
   end

   // One iteration of the active multi-cycle op.
   always_comb begin
      step_wrk = wrk;
      step_acc = acc;
      step_cf  = 1'b0;
      mul_sum  = {1'b0, acc} + (wrk[0] ? {1'b0, opd} : '0);
`ifdef ALU_SEQ_DIV_EN
      r_sh     = {acc, wrk[DW-1]};
      diff     = r_sh - {1'b0, opd};
`endif
      case (op_q)
         OP_SHL: begin
            step_wrk = {wrk[DW-2:0], 1'b0};
            step_cf  = wrk[DW-1];
         end
         OP_SHR: begin
            step_wrk = {1'b0, wrk[DW-1:1]};
            step_cf  = wrk[0];
         end
         OP_SAR: begin
            step_wrk = {wrk[DW-1], wrk[DW-1:1]};
            step_cf  = wrk[0];
         end
         OP_MUL: begin
            step_acc = mul_sum[DW:1];
            step_wrk = {mul_sum[0], wrk[DW-1:1]};
            step_cf  = (mul_sum[DW:1] != '0);
         end
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            if (!diff[DW]) begin
               step_acc = diff[DW-1:0];
               step_wrk = {wrk[DW-2:0], 1'b1};
            end else begin
               step_acc = r_sh[DW-1:0];
               step_wrk = {wrk[DW-2:0], 1'b0};
            end
         end
`endif
         default: begin
            step_wrk = wrk;
            step_acc = acc;
            step_cf  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= '0;
         wrk      <= '0;
         acc      <= '0;
         opd      <= '0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zf_q     <= 1'b0;
         cf_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (is_multi) begin
                     op_q   <= bus.op;
                     acc    <= '0;
                     wrk    <= (bus.op == OP_MUL) ? bus.b : bus.a;
                     opd    <= (bus.op == OP_MUL) ? bus.a : bus.b;
                     cnt    <= is_shift ? CNT_W'(k) : CNT_W'(DW);
                     busy_q <= 1'b1;
                     state  <= EXEC;
                  end else begin
                     result_q <= sc_res;
                     cf_q     <= sc_cf;
                     zf_q     <= (sc_res == '0);
                     done_q   <= 1'b1;
                  end
               end
            end
            EXEC: begin
               wrk <= step_wrk;
               acc <= step_acc;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  result_q <= step_wrk;
                  cf_q     <= step_cf;
                  zf_q     <= (step_wrk == '0);
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.zf     = zf_q;
   assign bus.cf     = cf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (DW=8); inputs driven and outputs sampled on negedge.
module tb_alu_seq;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   alu_seq_if #(.DW(8)) bus ();

   alu_seq #(.DW(8), .SHW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       cf;
      logic       zf;
      int         lat;
   } vec_t;

   // Issue one op at the current negedge; returns done latency (0 on timeout) and busy-cycle count.
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int nbusy);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      lat       = 0;
      nbusy     = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) bus.start = 1'b0;
         if (bus.busy) nbusy++;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 4'd0;
      bus.a     = 8'h00;
      bus.b     = 8'h00;
      repeat (2) @(negedge clk);
      checks += 5;
      if (bus.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      if (bus.done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      if (bus.result !== 8'h00)  begin failures++; $display("FAIL reset_result got=%h exp=00", bus.result); end
      if (bus.zf !== 1'b0)       begin failures++; $display("FAIL reset_zf got=%b exp=0", bus.zf); end
      if (bus.cf !== 1'b0)       begin failures++; $display("FAIL reset_cf got=%b exp=0", bus.cf); end
      rst = 1'b0;
   endtask

   task automatic test_add;
      int lat, nb;
      run_op(4'd0, 8'hF0, 8'h20, lat, nb);
      checks += 5;
      if (lat !== 1)             begin failures++; $display("FAIL add_lat got=%0d exp=1", lat); end
      if (nb !== 0)              begin failures++; $display("FAIL add_busy got=%0d exp=0", nb); end
      if (bus.result !== 8'h10)  begin failures++; $display("FAIL add_result got=%h exp=10", bus.result); end
      if (bus.cf !== 1'b1)       begin failures++; $display("FAIL add_cf got=%b exp=1", bus.cf); end
      if (bus.zf !== 1'b0)       begin failures++; $display("FAIL add_zf got=%b exp=0", bus.zf); end
      @(negedge clk);
      checks += 2;
      if (bus.done !== 1'b0)     begin failures++; $display("FAIL add_done_pulse got=%b exp=0", bus.done); end
      if (bus.result !== 8'h10)  begin failures++; $display("FAIL add_hold got=%h exp=10", bus.result); end
   endtask

   task automatic test_sub_back_to_back;
      int lat, nb;
      run_op(4'd1, 8'h05, 8'h05, lat, nb);
      checks += 4;
      if (lat !== 1)             begin failures++; $display("FAIL sub0_lat got=%0d exp=1", lat); end
      if (bus.result !== 8'h00)  begin failures++; $display("FAIL sub0_result got=%h exp=00", bus.result); end
      if (bus.zf !== 1'b1)       begin failures++; $display("FAIL sub0_zf got=%b exp=1", bus.zf); end
      if (bus.cf !== 1'b0)       begin failures++; $display("FAIL sub0_cf got=%b exp=0", bus.cf); end
      // issued in the done cycle of the previous op
      run_op(4'd1, 8'h03, 8'h05, lat, nb);
      checks += 4;
      if (lat !== 1)             begin failures++; $display("FAIL sub1_lat got=%0d exp=1", lat); end
      if (bus.result !== 8'hFE)  begin failures++; $display("FAIL sub1_result got=%h exp=fe", bus.result); end
      if (bus.cf !== 1'b1)       begin failures++; $display("FAIL sub1_cf got=%b exp=1", bus.cf); end
      if (bus.zf !== 1'b0)       begin failures++; $display("FAIL sub1_zf got=%b exp=0", bus.zf); end
   endtask

   task automatic test_vectors;
      vec_t tbl [12];
      int lat, nb;
      tbl[0]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
      tbl[1]  = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1};
      tbl[2]  = '{4'd4,  8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1};
      tbl[3]  = '{4'd5,  8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1};
      tbl[4]  = '{4'd6,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1};
      tbl[5]  = '{4'd7,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1};
      tbl[6]  = '{4'd12, 8'h5A, 8'h11, 8'h5A, 1'b0, 1'b0, 1};
      tbl[7]  = '{4'd8,  8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1};
      tbl[8]  = '{4'd8,  8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 4};
      tbl[9]  = '{4'd9,  8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 2};
      tbl[10] = '{4'd10, 8'h81, 8'h02, 8'hE0, 1'b0, 1'b0, 3};
      tbl[11] = '{4'd11, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 9};
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, nb);
         checks += 5;
         if (lat !== tbl[i].lat)
            begin failures++; $display("FAIL vec%0d_lat got=%0d exp=%0d", i, lat, tbl[i].lat); end
         if (nb !== tbl[i].lat - 1)
            begin failures++; $display("FAIL vec%0d_busy got=%0d exp=%0d", i, nb, tbl[i].lat - 1); end
         if (bus.result !== tbl[i].res)
            begin failures++; $display("FAIL vec%0d_result got=%h exp=%h", i, bus.result, tbl[i].res); end
         if (bus.cf !== tbl[i].cf)
            begin failures++; $display("FAIL vec%0d_cf got=%b exp=%b", i, bus.cf, tbl[i].cf); end
         if (bus.zf !== tbl[i].zf)
            begin failures++; $display("FAIL vec%0d_zf got=%b exp=%b", i, bus.zf, tbl[i].zf); end
         @(negedge clk);
      end
   endtask

   task automatic test_mul_ignore_start;
      int lat;
      bus.start = 1'b1;
      bus.op    = 4'd11;
      bus.a     = 8'h10;
      bus.b     = 8'h10;
      lat       = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) bus.start = 1'b0;
         if (i == 3) begin
            bus.start = 1'b1;
            bus.op    = 4'd0;
            bus.a     = 8'h01;
            bus.b     = 8'h01;
         end
         if (i == 4) bus.start = 1'b0;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      checks += 4;
      if (lat !== 9)             begin failures++; $display("FAIL mul_ign_lat got=%0d exp=9", lat); end
      if (bus.result !== 8'h00)  begin failures++; $display("FAIL mul_ign_result got=%h exp=00", bus.result); end
      if (bus.zf !== 1'b1)       begin failures++; $display("FAIL mul_ign_zf got=%b exp=1", bus.zf); end
      if (bus.cf !== 1'b1)       begin failures++; $display("FAIL mul_ign_cf got=%b exp=1", bus.cf); end
      @(negedge clk);
      checks += 2;
      if (bus.done !== 1'b0)     begin failures++; $display("FAIL mul_ign_done_after got=%b exp=0", bus.done); end
      if (bus.busy !== 1'b0)     begin failures++; $display("FAIL mul_ign_busy_after got=%b exp=0", bus.busy); end
   endtask

   task automatic test_div;
      int lat, nb;
`ifdef ALU_SEQ_DIV_EN
      run_op(4'd13, 8'h64, 8'h07, lat, nb);
      checks += 4;
      if (lat !== 9)             begin failures++; $display("FAIL div_lat got=%0d exp=9", lat); end
      if (bus.result !== 8'h0E)  begin failures++; $display("FAIL div_result got=%h exp=0e", bus.result); end
      if (bus.cf !== 1'b0)       begin failures++; $display("FAIL div_cf got=%b exp=0", bus.cf); end
      if (bus.zf !== 1'b0)       begin failures++; $display("FAIL div_zf got=%b exp=0", bus.zf); end
      run_op(4'd13, 8'h64, 8'h00, lat, nb);
      checks += 4;
      if (lat !== 1)             begin failures++; $display("FAIL div0_lat got=%0d exp=1", lat); end
      if (bus.result !== 8'hFF)  begin failures++; $display("FAIL div0_result got=%h exp=ff", bus.result); end
      if (bus.cf !== 1'b1)       begin failures++; $display("FAIL div0_cf got=%b exp=1", bus.cf); end
      if (bus.zf !== 1'b0)       begin failures++; $display("FAIL div0_zf got=%b exp=0", bus.zf); end
`else
      run_op(4'd13, 8'h64, 8'h07, lat, nb);
      checks += 3;
      if (lat !== 1)             begin failures++; $display("FAIL op13_lat got=%0d exp=1", lat); end
      if (bus.result !== 8'h64)  begin failures++; $display("FAIL op13_result got=%h exp=64", bus.result); end
      if (bus.cf !== 1'b0)       begin failures++; $display("FAIL op13_cf got=%b exp=0", bus.cf); end
`endif
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      int lat, nb;
      bit seen;
      run_op(4'd0, 8'hF0, 8'h20, lat, nb);
      bus.start = 1'b1;
      bus.op    = 4'd11;
      bus.a     = 8'h0F;
      bus.b     = 8'h11;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) bus.start = 1'b0;
      end
      checks += 1;
      if (bus.busy !== 1'b1)     begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", bus.busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks += 5;
      if (bus.busy !== 1'b0)     begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
      if (bus.done !== 1'b0)     begin failures++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
      if (bus.result !== 8'h00)  begin failures++; $display("FAIL rmid_result got=%h exp=00", bus.result); end
      if (bus.zf !== 1'b0)       begin failures++; $display("FAIL rmid_zf got=%b exp=0", bus.zf); end
      if (bus.cf !== 1'b0)       begin failures++; $display("FAIL rmid_cf got=%b exp=0", bus.cf); end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen = 1'b1;
      end
      checks += 1;
      if (seen !== 1'b0)         begin failures++; $display("FAIL rmid_no_done got=%b exp=0", seen); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_add();
      test_sub_back_to_back();
      test_vectors();
      test_mul_ignore_start();
      test_div();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
